// File: rtl/spi_byte_sequencer.sv
// spi_byte_sequencer
//   Command and data sequencer that sits in front of the LSB-first, mode-0 SPI
//   master core. It takes multi-byte write or read commands and feeds the core
//   one byte at a time through its tx_en/rx_en and tx_done/rx_done handshake.
//   Write bytes come from a small circular TX FIFO. Read bytes are returned as
//   one-cycle rd_valid strobes.
//
// Ports
//   sclk, rst_n                 clock, asynchronous active-low reset
//   cmd_valid/cmd_ready         command handshake (ready only while idle)
//   cmd_rw, cmd_len             0 = write / 1 = read, byte count (0 = no-op)
//   wr_data/wr_valid/wr_ready   TX FIFO push port; fifo_level = occupancy
//   rd_data, rd_valid           received byte and its one-cycle strobe
//   busy, done                  command in progress, completion pulse
//   tx_en, rx_en, data_in,
//   data_vaild                  drive side of the SPI core
//   tx_done, rx_done, data_out  completion flags and receive data from the core
module spi_byte_sequencer #(
  parameter int WORD_SIZE = 8,
  parameter int DEPTH     = 4,
  parameter int LEN_W     = 8
) (
  input  logic                     sclk,
  input  logic                     rst_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_rw,
  input  logic [LEN_W-1:0]         cmd_len,
  input  logic [WORD_SIZE-1:0]     wr_data,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic [WORD_SIZE-1:0]     rd_data,
  output logic                     rd_valid,
  output logic                     busy,
  output logic                     done,
  output logic                     tx_en,
  output logic                     rx_en,
  output logic [WORD_SIZE-1:0]     data_in,
  output logic                     data_vaild,
  input  logic                     tx_done,
  input  logic                     rx_done,
  input  logic [WORD_SIZE-1:0]     data_out
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [2:0] {IDLE, LOAD, TX, RX, GAP, FINISH} state_e;

  state_e                 state_q;
  logic                   rw_q;
  logic [LEN_W-1:0]       remaining_q;
  logic [WORD_SIZE-1:0]   tx_byte_q;
  logic [WORD_SIZE-1:0]   rd_data_q;
  logic                   rd_valid_q;

  logic [WORD_SIZE-1:0]   mem_q [DEPTH];
  logic [PTR_W-1:0]       rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0]       count_q, count_d;

  logic                   fifo_empty, fifo_full, pop, push;

  // Remaining-byte counter saturates at zero.
  function automatic logic [LEN_W-1:0] sat_dec(input logic [LEN_W-1:0] v);
    return (v == '0) ? v : v - LEN_W'(1);
  endfunction

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CNT_W'(DEPTH));
  assign pop        = (state_q == LOAD) && !fifo_empty;
  // A pop in the same cycle frees a slot, so a push is taken even when full.
  assign push       = wr_valid && (!fifo_full || pop);

  always_comb begin
    count_d = count_q;
    if (push && !pop)      count_d = count_q + CNT_W'(1);
    else if (pop && !push) count_d = count_q - CNT_W'(1);
  end

  // TX FIFO pointers and occupancy
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

  // FIFO storage carries no reset; emptiness is tracked by count_q.
  always_ff @(posedge sclk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

  // Sequencer FSM
  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rw_q        <= 1'b0;
      remaining_q <= '0;
      tx_byte_q   <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
    end else begin
      rd_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            rw_q        <= cmd_rw;
            remaining_q <= cmd_len;
            if (cmd_len == '0)  state_q <= FINISH;
            else if (cmd_rw)    state_q <= RX;
            else                state_q <= LOAD;
          end
        end
        LOAD: begin
          // Stall here on underrun; tx_en stays low so the core releases CS.
          if (!fifo_empty) begin
            tx_byte_q <= mem_q[rd_ptr_q];
            state_q   <= TX;
          end
        end
        TX: begin
          if (tx_done) begin
            remaining_q <= sat_dec(remaining_q);
            state_q     <= GAP;
          end
        end
        RX: begin
          if (rx_done) begin
            rd_data_q   <= data_out;
            rd_valid_q  <= 1'b1;
            remaining_q <= sat_dec(remaining_q);
            state_q     <= GAP;
          end
        end
        GAP: begin
          // Wait for the core to clear its done flags before the next byte.
          if (!tx_done && !rx_done) begin
            if (remaining_q == '0) state_q <= FINISH;
            else if (rw_q)         state_q <= RX;
            else                   state_q <= LOAD;
          end
        end
        FINISH:  state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Outputs are decodes of registered state, so reset drops them at once.
  assign cmd_ready  = (state_q == IDLE);
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == FINISH);
  assign tx_en      = (state_q == TX);
  assign rx_en      = (state_q == RX);
  assign data_vaild = pop;
  assign data_in    = (state_q == LOAD) ? mem_q[rd_ptr_q] : tx_byte_q;
  assign wr_ready   = !fifo_full;
  assign fifo_level = count_q;
  assign rd_data    = rd_data_q;
  assign rd_valid   = rd_valid_q;

endmodule

// File: tb/tb_spi_byte_sequencer.sv
module tb_spi_byte_sequencer;
  localparam int WS    = 8;
  localparam int DEPTH = 4;
  localparam int LEN_W = 8;

  logic             sclk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic             cmd_rw = 1'b0;
  logic [LEN_W-1:0] cmd_len = '0;
  logic [WS-1:0]    wr_data = '0;
  logic             wr_valid = 1'b0;
  logic             wr_ready;
  logic [2:0]       fifo_level;
  logic [WS-1:0]    rd_data;
  logic             rd_valid;
  logic             busy, done, tx_en, rx_en, data_vaild;
  logic [WS-1:0]    data_in;
  logic             tx_done = 1'b0;
  logic             rx_done = 1'b0;
  logic [WS-1:0]    data_out = '0;

  spi_byte_sequencer #(.WORD_SIZE(WS), .DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
    .sclk(sclk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rw(cmd_rw), .cmd_len(cmd_len),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready), .fifo_level(fifo_level),
    .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy), .done(done),
    .tx_en(tx_en), .rx_en(rx_en), .data_in(data_in), .data_vaild(data_vaild),
    .tx_done(tx_done), .rx_done(rx_done), .data_out(data_out)
  );

  always #5 sclk = ~sclk;

  int checks = 0;
  int passed = 0;

  // Core model state and observation logs
  logic [WS-1:0] mosi_log [$];
  logic [WS-1:0] rd_log   [$];
  logic [WS-1:0] miso_q   [$];
  logic [WS-1:0] mosi_sh = '0;
  logic [3:0]    tx_bits = '0;
  logic [3:0]    rx_bits = '0;
  logic          tx_en_prev = 1'b0;
  int            tx_windows = 0;
  int            done_cnt = 0;
  int            rd_at_done = 0;
  int            viol = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Simple SPI core model: 8 bit-times per byte, done flag held until enable drops.
  initial begin
    forever begin
      @(posedge sclk);
      #1;
      if (!rst_n) begin
        tx_done = 1'b0; rx_done = 1'b0; tx_bits = '0; rx_bits = '0; tx_en_prev = 1'b0;
      end else begin
        if (tx_en && rx_en) viol++;
        if (data_vaild && (tx_en || rx_en)) viol++;
        if (tx_en && !tx_en_prev) tx_windows++;
        tx_en_prev = tx_en;
        if (tx_en) begin
          if (!tx_done) begin
            mosi_sh = {data_in[tx_bits[2:0]], mosi_sh[WS-1:1]};
            tx_bits = tx_bits + 4'd1;
            if (tx_bits == 4'd8) begin
              tx_done = 1'b1; tx_bits = '0; mosi_log.push_back(mosi_sh);
            end
          end
        end else tx_done = 1'b0;
        if (rx_en) begin
          if (!rx_done) begin
            rx_bits = rx_bits + 4'd1;
            if (rx_bits == 4'd8) begin
              rx_done = 1'b1; rx_bits = '0;
              data_out = (miso_q.size() > 0) ? miso_q.pop_front() : 8'h00;
            end
          end
        end else rx_done = 1'b0;
        if (rd_valid) rd_log.push_back(rd_data);
        if (done) begin done_cnt++; rd_at_done = rd_log.size(); end
      end
    end
  end

  task automatic tick();
    @(posedge sclk);
    #2;
  endtask

  task automatic push(input logic [WS-1:0] d);
    wr_data = d; wr_valid = 1'b1;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic send_cmd(input logic rw, input logic [LEN_W-1:0] len);
    cmd_rw = rw; cmd_len = len; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int target);
    for (int i = 0; i < 400 && done_cnt < target; i++) tick();
    check("done_count", done_cnt, target);
    tick();
  endtask

  int d0, w0, m0;

  initial begin
    // Reset state
    repeat (2) tick();
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_wr_ready", wr_ready, 1);
    check("rst_level", fifo_level, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_tx_en", tx_en, 0);
    check("rst_rx_en", rx_en, 0);
    check("rst_dvld", data_vaild, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_data", rd_data, 0);
    rst_n = 1'b1;
    tick();

    // Two-byte write
    push(8'hA5); push(8'h3C);
    check("w2_level2", fifo_level, 2);
    d0 = done_cnt; w0 = tx_windows; m0 = mosi_log.size();
    send_cmd(1'b0, 8'd2);
    check("w2_dvld", data_vaild, 1);
    check("w2_data_in", data_in, 8'hA5);
    check("w2_cmd_ready", cmd_ready, 0);
    check("w2_tx_en_lo", tx_en, 0);
    tick();
    check("w2_tx_en_hi", tx_en, 1);
    check("w2_level1", fifo_level, 1);
    wait_done(d0 + 1);
    check("w2_mosi_n", mosi_log.size(), m0 + 2);
    check("w2_mosi0", mosi_log[m0], 8'hA5);
    check("w2_mosi1", mosi_log[m0 + 1], 8'h3C);
    check("w2_windows", tx_windows, w0 + 2);
    check("w2_level0", fifo_level, 0);
    check("w2_idle", busy, 0);

    // Three-byte read, one byte sitting in the FIFO throughout
    push(8'h11);
    miso_q.push_back(8'h81); miso_q.push_back(8'h7E); miso_q.push_back(8'h55);
    d0 = done_cnt; w0 = tx_windows;
    send_cmd(1'b1, 8'd3);
    check("rd_rx_en", rx_en, 1);
    check("rd_dvld", data_vaild, 0);
    wait_done(d0 + 1);
    check("rd_n", rd_log.size(), 3);
    check("rd_b0", rd_log[0], 8'h81);
    check("rd_b1", rd_log[1], 8'h7E);
    check("rd_b2", rd_log[2], 8'h55);
    check("rd_before_done", rd_at_done, 3);
    check("rd_hold", rd_data, 8'h55);
    check("rd_fifo_kept", fifo_level, 1);
    check("rd_no_tx", tx_windows, w0);

    // Underrun stall: len=2 with one byte queued
    d0 = done_cnt; m0 = mosi_log.size();
    send_cmd(1'b0, 8'd2);
    repeat (20) tick();
    check("st_busy", busy, 1);
    check("st_tx_en", tx_en, 0);
    check("st_dvld", data_vaild, 0);
    check("st_level", fifo_level, 0);
    check("st_no_done", done_cnt, d0);
    check("st_one_byte", mosi_log.size(), m0 + 1);
    push(8'h0F);
    wait_done(d0 + 1);
    check("st_mosi0", mosi_log[m0], 8'h11);
    check("st_mosi1", mosi_log[m0 + 1], 8'h0F);

    // Full FIFO, dropped push, push+pop while full
    push(8'h01); push(8'h02); push(8'h03); push(8'h04);
    check("full_level", fifo_level, 4);
    check("full_wr_ready", wr_ready, 0);
    push(8'h05);
    check("drop_level", fifo_level, 4);
    d0 = done_cnt; m0 = mosi_log.size();
    send_cmd(1'b0, 8'd1);
    check("pp_dvld", data_vaild, 1);
    check("pp_head", data_in, 8'h01);
    wr_data = 8'h06; wr_valid = 1'b1;
    tick();
    wr_valid = 1'b0;
    check("pp_level", fifo_level, 4);
    wait_done(d0 + 1);
    check("pp_mosi", mosi_log[m0], 8'h01);
    send_cmd(1'b0, 8'd4);
    wait_done(d0 + 2);
    check("drain_n", mosi_log.size(), m0 + 5);
    check("drain0", mosi_log[m0 + 1], 8'h02);
    check("drain1", mosi_log[m0 + 2], 8'h03);
    check("drain2", mosi_log[m0 + 3], 8'h04);
    check("drain3", mosi_log[m0 + 4], 8'h06);
    check("drain_level", fifo_level, 0);

    // Zero-length command
    d0 = done_cnt; w0 = tx_windows;
    send_cmd(1'b0, 8'd0);
    check("z_done", done, 1);
    check("z_tx_en", tx_en, 0);
    check("z_rx_en", rx_en, 0);
    tick();
    check("z_done_lo", done, 0);
    check("z_idle", cmd_ready, 1);
    check("z_count", done_cnt, d0 + 1);
    check("z_windows", tx_windows, w0);

    // Reset in the middle of TX
    push(8'hAA); push(8'hBB);
    send_cmd(1'b0, 8'd1);
    tick();
    check("rt_tx_en", tx_en, 1);
    check("rt_level", fifo_level, 1);
    rst_n = 1'b0;
    #1;
    check("rt_tx_drop", tx_en, 0);
    check("rt_level0", fifo_level, 0);
    check("rt_ready", cmd_ready, 1);
    tick();
    rst_n = 1'b1;
    tick();
    check("rt_busy", busy, 0);
    check("rt_level_after", fifo_level, 0);
    check("rt_cmd_ready", cmd_ready, 1);
    check("rt_wr_ready", wr_ready, 1);

    check("exclusive_enables", viol, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/spi_byte_sequencer.md
# spi_byte_sequencer

Upstream command/data sequencer for the SPI master core (`spi_module`, WORD_SIZE-bit, LSB-first, mode 0).
- Accepts multi-byte write or read commands over a valid/ready interface.
- Buffers transmit bytes in a small FIFO.
- Drives the core's `tx_en`/`rx_en`/`data_in`/`data_vaild` one byte at a time, using the core's `tx_done`/`rx_done` handshake.
- Returns received bytes as single-cycle strobes.

## Interface
Parameters:
- WORD_SIZE, 8, byte width; must match the core.
- DEPTH, 4, TX FIFO entries; power of two, ≥2.
- LEN_W, 8, width of the command byte count.

Ports:
- sclk  in  1  system clock; one clock only, all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when high with cmd_valid; equals (state==IDLE).
- cmd_rw  in  1  0 = write, 1 = read.
- cmd_len  in  LEN_W  number of bytes; 0 = no-op.
- wr_data  in  WORD_SIZE  TX FIFO push data.
- wr_valid  in  1  push request.
- wr_ready  out  1  FIFO not full.
- fifo_level  out  clog2(DEPTH)+1  current FIFO occupancy.
- rd_data  out  WORD_SIZE  received byte; held until the next capture.
- rd_valid  out  1  one-cycle strobe per received byte.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse at command completion.
- tx_en, rx_en  out  1  enables to the core.
- data_in  out  WORD_SIZE  byte to the core.
- data_vaild  out  1  load strobe to the core.
- tx_done, rx_done  in  1  completion flags from the core; remain high until the corresponding enable drops.
- data_out  in  WORD_SIZE  core receive data; valid while rx_done is high.

## Operation
- States: IDLE, LOAD, TX, RX, GAP, FINISH.
- **IDLE**
  - On cmd_valid: latch cmd_rw into rw and cmd_len into remaining.
  - If len == 0, go to FINISH.
  - Else go to LOAD for a write, RX for a read.
- **LOAD**
  - Wait while the FIFO is empty (underrun stall; tx_en stays low, so the core deasserts chip select).
  - When non-empty: pop one entry, drive data_in = head, data_vaild = 1 for this cycle, go to TX.
- **TX**
  - tx_en = 1 and data_in held.
  - When tx_done is sampled high: decrement remaining, go to GAP.
- **RX**
  - rx_en = 1.
  - When rx_done is sampled high: rd_data <= data_out, rd_valid = 1 next cycle, decrement remaining, go to GAP.
- **GAP**
  - tx_en = rx_en = 0 for at least one cycle.
  - Stay until tx_done and rx_done are both low.
  - Then go to FINISH if remaining == 0, else LOAD (write) or RX (read).
- **FINISH**
  - done = 1 for one cycle, then IDLE.
- tx_en and rx_en are never high together; data_vaild is never high while tx_en or rx_en is high.
- **FIFO**
  - Circular buffer with rd_ptr/wr_ptr (clog2(DEPTH) bits, natural wrap) and a count.
  - Push when wr_valid && wr_ready. A push while full is dropped with no state change.
  - Simultaneous push and pop: count unchanged, both pointers advance; valid even when full (the pop frees the slot first).
  - FIFO contents persist across commands; read commands do not touch the FIFO.
- remaining: LEN_W-bit down-counter; never decremented below 0.

## Timing
- Reset values (asynchronous):
  - state = IDLE; FIFO empty; remaining = 0; rd_data = 0.
  - rd_valid, done, tx_en, rx_en, data_vaild, busy = 0.
  - cmd_ready = 1, wr_ready = 1, fifo_level = 0.
  - Reset mid-transfer drops the enables immediately and discards any queued data.
- Command accepted at edge N → first LOAD (or RX) cycle is N+1. With a non-empty FIFO, data_vaild is high in cycle N+1 and tx_en rises at N+2.
- Byte-to-byte overhead is GAP (≥1 cycle, as long as the core's done flag stays high) plus LOAD (1 cycle).
- done pulses exactly once per accepted command, including len = 0 (IDLE→FINISH→IDLE, done in cycle N+1).
- rd_valid for the last byte of a read precedes the done pulse.
- cmd_valid during busy is ignored; cmd_ready = 0.

## Test plan
- Push 0xA5, 0x3C; then write cmd len=2 → MOSI carries 0xA5 then 0x3C, LSB first; two tx_en windows separated by ≥1 cycle of tx_en low; one done pulse; fifo_level goes 2→1→0.
- Read cmd len=3, MISO model returns 0x81, 0x7E, 0x55 → three rd_valid strobes with those values; done after the third strobe; FIFO untouched.
- Write cmd len=2 with only 1 byte queued → stalls in LOAD with tx_en=0 and busy=1; pushing 0x0F resumes the command and completes with done.
- Fill the FIFO (4 pushes), attempt a 5th push → wr_ready=0, the push is dropped; a push and pop in the same cycle while full keeps level at 4.
- cmd len=0 → done one cycle after acceptance; no enables asserted.
- Assert rst_n low during TX → tx_en=0 immediately; after release, state IDLE, fifo_level=0, cmd_ready=1.
